draw_cmd_scheduler: RTL

Command front-end for the primitive draw unit (line/triangle/rect/circle).
- Buffers draw commands in a small FIFO and presents one command at a time on the draw unit's TYPE/coordinate inputs.
- Sequences ENB around the draw unit's registered type decode and its FINISH flag.
- Streams the generated pixel coordinates to the framebuffer write port, tagged with a per-command colour.

---
 rtl/draw_cmd_scheduler.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/draw_cmd_scheduler.sv
// draw_cmd_scheduler: command FIFO and sequencer in front of the primitive
// draw unit. It pops one command at a time and drives DU_TYPE and the
// coordinates from registers. DU_ENB is held low long enough for the draw
// unit's registered decode to settle. Generated pixels are streamed to the
// framebuffer port with the colour of the command.
//
// Optional build macro DRAW_TIMEOUT_EN adds a DRAW watchdog and a TIMEOUT
// output pulse. Without it, DRAW waits for DU_FINISH indefinitely.
//
// state  | meaning
// IDLE   | wait for a queued command; pop it into the DU output registers
// CHECK  | one cycle: discard an invalid type, else arm the settle timer
// SETTLE | DU_ENB low while the draw unit latches TYPE; DU_FINISH ignored
// DRAW   | DU_ENB high; forward pixels until DU_FINISH (or watchdog)
// DONE   | one cycle with DU_ENB low so the draw sub-engine re-arms

module draw_cmd_scheduler #(
  parameter int DEPTH          = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       ACLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [7:0] CMD_TYPE,
  input  logic [7:0] CMD_X0,
  input  logic [7:0] CMD_Y0,
  input  logic [7:0] CMD_X1,
  input  logic [7:0] CMD_Y1,
  input  logic [7:0] CMD_X2,
  input  logic [7:0] CMD_Y2,
  input  logic [7:0] CMD_COLOR,
  output logic       DU_ENB,
  output logic [7:0] DU_TYPE,
  output logic [7:0] DU_X0,
  output logic [7:0] DU_Y0,
  output logic [7:0] DU_X1,
  output logic [7:0] DU_Y1,
  output logic [7:0] DU_X2,
  output logic [7:0] DU_Y2,
  input  logic [7:0] DU_X,
  input  logic [7:0] DU_Y,
  input  logic       DU_FINISH,
  output logic       PIX_WE,
  output logic [7:0] PIX_X,
  output logic [7:0] PIX_Y,
  output logic [7:0] PIX_COLOR,
`ifdef DRAW_TIMEOUT_EN
  output logic       TIMEOUT,
`endif
  output logic       BUSY,
  output logic       CMD_DROPPED
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  // Reject parameter values the pointer and timer arithmetic cannot support.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SETTLE, S_DRAW, S_DONE} state_t;

  typedef struct packed {
    logic [7:0] typ;
    logic [7:0] x0, y0, x1, y1, x2, y2;
    logic [7:0] color;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  cmd_t          cur_q, cur_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          pix_we_q, pix_we_d;
  logic [7:0]    pix_x_q, pix_x_d, pix_y_q, pix_y_d, pix_c_q, pix_c_d;
  logic          push, pop, dropped, to_hit;
`ifdef DRAW_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]   wd_q, wd_d;
`endif

  assign CMD_READY = (count_q < DEPTH_C);
  assign push      = CMD_VALID & CMD_READY;

  // Next-state, FIFO pop and pixel forwarding.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    settle_d = settle_q;
    pix_we_d = 1'b0;
    pix_x_d  = pix_x_q;
    pix_y_d  = pix_y_q;
    pix_c_d  = pix_c_q;
    pop      = 1'b0;
    dropped  = 1'b0;
    to_hit   = 1'b0;
`ifdef DRAW_TIMEOUT_EN
    wd_d     = wd_q;
    to_hit   = (state_q == S_DRAW) && (wd_q == TMO_LAST);
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          cur_d   = mem_q[rd_ptr_q];
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cur_q.typ[7:2] > 6'd3) begin
          dropped = 1'b1;
          state_d = S_IDLE;
        end else begin
          settle_d = SETTLE_LOAD;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == '0) begin
          state_d = S_DRAW;
`ifdef DRAW_TIMEOUT_EN
          wd_d    = '0;
`endif
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      S_DRAW: begin
`ifdef DRAW_TIMEOUT_EN
        wd_d = wd_q + 16'd1;
`endif
        if (DU_FINISH || to_hit) begin
          state_d = S_DONE;
        end else begin
          pix_we_d = 1'b1;
          pix_x_d  = DU_X;
          pix_y_d  = DU_Y;
          pix_c_d  = cur_q.color;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointer and occupancy update; a simultaneous push and pop keeps count.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Command storage; entries need no reset because count gates every read.
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{typ: CMD_TYPE, x0: CMD_X0, y0: CMD_Y0, x1: CMD_X1,
                           y1: CMD_Y1, x2: CMD_X2, y2: CMD_Y2, color: CMD_COLOR};
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cur_q    <= '0;
      settle_q <= '0;
      pix_we_q <= 1'b0;
      pix_x_q  <= '0;
      pix_y_q  <= '0;
      pix_c_q  <= '0;
`ifdef DRAW_TIMEOUT_EN
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cur_q    <= cur_d;
      settle_q <= settle_d;
      pix_we_q <= pix_we_d;
      pix_x_q  <= pix_x_d;
      pix_y_q  <= pix_y_d;
      pix_c_q  <= pix_c_d;
`ifdef DRAW_TIMEOUT_EN
      wd_q     <= wd_d;
`endif
    end
  end

  assign DU_ENB      = (state_q == S_DRAW);
  assign DU_TYPE     = cur_q.typ;
  assign DU_X0       = cur_q.x0;
  assign DU_Y0       = cur_q.y0;
  assign DU_X1       = cur_q.x1;
  assign DU_Y1       = cur_q.y1;
  assign DU_X2       = cur_q.x2;
  assign DU_Y2       = cur_q.y2;
  assign PIX_WE      = pix_we_q;
  assign PIX_X       = pix_x_q;
  assign PIX_Y       = pix_y_q;
  assign PIX_COLOR   = pix_c_q;
  assign BUSY        = (count_q != '0) || (state_q != S_IDLE);
  assign CMD_DROPPED = dropped;
`ifdef DRAW_TIMEOUT_EN
  assign TIMEOUT     = to_hit;
`endif

endmodule
